serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial adder sequencer built around one instance of the existing full_adder cell (ports A, B, Cin, Sum, Cout). It accepts a WIDTH-bit operand pair and a carry-in on a start pulse. It then feeds one bit pair per clock, LSB first, through the single full_adder, holding the carry in a flip-flop between bits. It presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse, trading latency for area against a parallel ripple adder.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock; one clock domain
rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronous to clk externally
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; sampled on accepted start
b  input  WIDTH  operand B; sampled on accepted start
cin  input  1  carry-in; sampled on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; sum/cout valid
sum  output  WIDTH  registered result; held until next completion
cout  output  1  registered carry-out; held until next completion

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; all internal shift registers, the carry register and the bit counter are 0.
- States: IDLE, RUN, DONE. The state register is the only source of busy/done: busy=(state==RUN), done=(state==DONE).
- IDLE: start=1 at a rising edge loads a_sh<=a, b_sh<=b, carry<=cin and cnt<=0, then moves to RUN. start=0 stays in IDLE.
- RUN datapath: full_adder.A=a_sh[0], full_adder.B=b_sh[0], full_adder.Cin=carry. Each edge does the following:
  - a_sh and b_sh shift right by 1, zero-filled.
  - res_sh<={Sum, res_sh[WIDTH-1:1]}.
  - carry<=Cout.
  - cnt<=cnt+1.
- RUN exit: at the edge where cnt==WIDTH-1, sum<={Sum, res_sh[WIDTH-1:1]} and cout<=Cout, and the state moves to DONE. Exactly WIDTH edges are spent in RUN.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- Latency: if start is sampled at edge E0, busy is high from E0 to E_WIDTH and done is high from E_WIDTH to E_WIDTH+1. The earliest next start is accepted at E_WIDTH+2, giving a period of WIDTH+2 cycles.
- start is ignored while in RUN or DONE: no queuing, no effect on the operation in progress.
- a, b and cin may change freely after the accepting edge; only the values at that edge are used.
- sum and cout change only at the final RUN edge. A partial result is never visible on the outputs.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1). Operands are unsigned, with no overflow flag.
- cnt width is $clog2(WIDTH). cnt does not wrap within an operation because exit occurs at WIDTH-1.
- Reset asserted mid-RUN or mid-DONE: immediate return to the reset state. No done pulse is produced, and sum/cout are cleared to 0.
- start held high continuously: a new operation begins on every IDLE cycle, i.e. every WIDTH+2 cycles.

Test Plan:
1. Reset check: rst_n=0 with no clock edges, then release -> busy=0, done=0, sum=8'h00, cout=0. Then start=0 for 5 cycles -> outputs unchanged.
2. Directed add, WIDTH=8, a=8'h5A, b=8'h3C, cin=0, one-cycle start at E0:
   - busy high for 8 cycles.
   - done high for exactly 1 cycle after E8.
   - sum=8'h96, cout=0.
3. Carry chain cases:
   - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
   - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
   - a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
4. Ignored start: start a=8'h10, b=8'h20. At E3, pulse start with a=8'hAA, b=8'h55 and change inputs -> one done only, at E8, with sum=8'h30. No second done without a new start in IDLE.
5. Reset mid-operation: start a=8'hF0, b=8'h0F, cin=1, then drop rst_n at E4 -> sum=0, cout=0, busy=0 immediately, and no done. After release, a=8'h01+b=8'h01 -> sum=8'h02.
6. Back-to-back: hold start=1 with a=8'h80, b=8'h80 -> done pulses at E8, E18, E28, each with sum=8'h00, cout=1. Also run an exhaustive random compare against a+b+cin for WIDTH=4 over all 512 input combinations.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full_adder cell, one bit pair per clock, LSB first.
// Trades WIDTH+2 cycles of latency per operation for a single-bit datapath.

module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic [WIDTH-1:0]   res_sh_reg;
    logic               carry_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               cout_reg;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   res_next;
    logic               unused_res_lsb;

    full_adder u_fa (
        .A    (a_sh_reg[0]),
        .B    (b_sh_reg[0]),
        .Cin  (carry_reg),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // New bit enters at the MSB so after WIDTH shifts bit 0 of the result sits at bit 0.
    assign res_next       = {fa_sum, res_sh_reg[WIDTH-1:1]};
    assign unused_res_lsb = res_sh_reg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    res_sh_reg <= res_next;
                    carry_reg  <= fa_cout;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        sum_reg   <= res_next;
                        cout_reg  <= fa_cout;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 directed cases plus an exhaustive WIDTH=4 sweep.

module tb_serial_adder_ctrl;
    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitors: each completion pops the oldest expected {cout,sum}.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("w8 unexpected done", 32'(done8), 32'd0);
            end else begin
                check("w8 result", 32'({cout8, sum8}), 32'(q8.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                check("w4 unexpected done", 32'(done4), 32'd0);
            end else begin
                n_vec++;
                if ({cout4, sum4} !== q4[0]) begin
                    n_err++;
                    $display("FAIL w4 result a=%0h b=%0h: got 0x%0h, expected 0x%0h",
                             a4, b4, {cout4, sum4}, q4[0]);
                end
                void'(q4.pop_front());
            end
        end
    end

    // One WIDTH=8 operation; checks busy length and that done lands exactly 8 edges after start.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic [8:0] exp, input string name);
        int         busy_cnt;
        logic [9:0] dmask;
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        q8.push_back(exp);
        busy_cnt = 0;
        dmask    = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start8 = 1'b0;
                a8 = ~av; b8 = ~bv; cin8 = ~cv;
            end
            busy_cnt += int'(busy8);
            dmask[k] = done8;
        end
        check({name, " busy cycles"}, 32'(busy_cnt), 32'd8);
        check({name, " done timing"}, 32'(dmask), 32'h100);
    endtask

    initial begin
        logic [13:0] dmask14;
        logic [31:0] dmask32;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #2;
        check("reset busy", 32'(busy8), 32'd0);
        check("reset done", 32'(done8), 32'd0);
        check("reset sum/cout", 32'({cout8, sum8}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle outputs", 32'({busy8, done8, cout8, sum8}), 32'd0);
        end

        run8(8'h5A, 8'h3C, 1'b0, 9'h096, "5A+3C");
        run8(8'hFF, 8'h01, 1'b0, 9'h100, "FF+01");
        run8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "FF+FF+1");
        run8(8'h00, 8'h00, 1'b1, 9'h001, "00+00+1");

        // Start pulse during RUN must be ignored.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h030);
        dmask14 = '0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 0) start8 = 1'b0;
            if (k == 2) begin
                start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
            end
            if (k == 3) start8 = 1'b0;
            dmask14[k] = done8;
        end
        check("ignored start done timing", 32'(dmask14), 32'h100);

        // Reset during RUN: outputs clear immediately, pending result is abandoned.
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrun reset busy", 32'(busy8), 32'd0);
        check("midrun reset sum/cout", 32'({cout8, sum8}), 32'd0);
        dmask14 = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            dmask14[k] = done8;
            if (k == 2) rst_n = 1'b1;
        end
        check("midrun reset no done", 32'(dmask14), 32'd0);
        run8(8'h01, 8'h01, 1'b0, 9'h002, "01+01");

        // start held high: a new operation every WIDTH+2 cycles.
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h100); q8.push_back(9'h100); q8.push_back(9'h100);
        dmask32 = '0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k == 28) start8 = 1'b0;
            dmask32[k] = done8;
        end
        check("back-to-back done timing", dmask32, 32'h1004_0100);

        // Exhaustive WIDTH=4 sweep.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            @(negedge clk);
            a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; start4 = 1'b1;
            q4.push_back(5'({1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]}));
            @(negedge clk);
            start4 = 1'b0;
            repeat (5) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("w8 pending results", 32'(q8.size()), 32'd0);
        check("w4 pending results", 32'(q4.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
